// File: rtl/keypad_matrix_emu.sv
// Purpose: emulates a 4x4 matrix keypad, turning key commands into timed press/bounce/release on row lines.
// Latency: press visible on pressed at the accept edge, on row one clk later; sequence length fixed by tick parameters.
// Backpressure: cmd_ready is low for the whole key sequence; commands do not queue.
module keypad_matrix_emu #(
    parameter int TICK_DIV     = 1048576,
    parameter int HOLD_TICKS   = 16,
    parameter int GAP_TICKS    = 16,
    parameter int BOUNCE_TICKS = 0,
    parameter int BOUNCE_SHIFT = 12
) (
    input  logic       clk,
    input  logic       enable,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       cmd_valid,
    input  logic [4:0] cmd_key,
    output logic       cmd_ready,
    output logic       cmd_err,
    output logic       pressed,
    output logic       busy,
    output logic       done
);

    localparam int HG_MAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int MAX_T  = (HG_MAX > BOUNCE_TICKS) ? HG_MAX : BOUNCE_TICKS;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int PW     = $clog2(TICK_DIV);
    localparam int PHW    = BOUNCE_SHIFT + 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] BNC_LAST   = TW'((BOUNCE_TICKS > 0) ? BOUNCE_TICKS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        B_PRESS = 3'd1,
        HOLD    = 3'd2,
        B_REL   = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc_cnt;
    logic [TW-1:0]   tick_cnt;
    logic [PHW-1:0]  ph_cnt;
    logic [PHW-1:0]  ph_nxt;
    logic [1:0]      key_r;
    logic [1:0]      key_c;
    logic            key_ok;
    logic [3:0]      key_idx;
    logic            tick_end;
    logic            state_end;
    logic [3:0]      row_nxt;

    assign key_ok   = (cmd_key != 5'd0) && (cmd_key <= 5'd16);
    assign key_idx  = 4'(cmd_key - 5'd1);
    assign tick_end = (presc_cnt == PRESC_LAST);
    assign ph_nxt   = ph_cnt + PHW'(1);

    // Decide whether the current state has used up its full duration this cycle
    always_comb begin
        state_end = 1'b0;
        case (state)
            B_PRESS, B_REL: state_end = tick_end && (tick_cnt == BNC_LAST);
            HOLD:           state_end = tick_end && (tick_cnt == HOLD_LAST);
            GAP:            state_end = tick_end && (tick_cnt == GAP_LAST);
            default:        state_end = 1'b0;
        endcase
    end

    // Key sequencer: command acceptance, timed phases, contact state and status pulses
    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            state     <= IDLE;
            presc_cnt <= '0;
            tick_cnt  <= '0;
            ph_cnt    <= '0;
            key_r     <= 2'd0;
            key_c     <= 2'd0;
            pressed   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            ph_cnt  <= ph_nxt;
            // Free-running tick timebase inside a phase; every phase change below restarts it
            if (tick_end) begin
                presc_cnt <= '0;
                tick_cnt  <= tick_cnt + TW'(1);
            end else begin
                presc_cnt <= presc_cnt + PW'(1);
            end
            case (state)
                IDLE: begin
                    presc_cnt <= '0;
                    tick_cnt  <= '0;
                    pressed   <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        if (key_ok) begin
                            key_r     <= key_idx[3:2];
                            key_c     <= key_idx[1:0];
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            // Bounce phase also starts closed, so both paths close the contact now
                            pressed   <= 1'b1;
                            ph_cnt    <= '0;
                            state     <= (BOUNCE_TICKS > 0) ? B_PRESS : HOLD;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                B_PRESS: begin
                    if (state_end) begin
                        presc_cnt <= '0;
                        tick_cnt  <= '0;
                        pressed   <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        pressed <= ~ph_nxt[BOUNCE_SHIFT];
                    end
                end
                HOLD: begin
                    if (state_end) begin
                        presc_cnt <= '0;
                        tick_cnt  <= '0;
                        ph_cnt    <= '0;
                        pressed   <= 1'b0;
                        state     <= (BOUNCE_TICKS > 0) ? B_REL : GAP;
                    end else begin
                        pressed <= 1'b1;
                    end
                end
                B_REL: begin
                    if (state_end) begin
                        presc_cnt <= '0;
                        tick_cnt  <= '0;
                        pressed   <= 1'b0;
                        state     <= GAP;
                    end else begin
                        pressed <= ph_nxt[BOUNCE_SHIFT];
                    end
                end
                GAP: begin
                    pressed <= 1'b0;
                    if (state_end) begin
                        presc_cnt <= '0;
                        tick_cnt  <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Closed contact pulls its row low only while the scanner selects its column
    always_comb begin
        row_nxt = 4'hF;
        if (pressed && !col[key_c]) begin
            row_nxt[key_r] = 1'b0;
        end
    end

    // Register the row sense so the scanner sees a clean, one-cycle-delayed response
    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            row <= 4'hF;
        end else begin
            row <= row_nxt;
        end
    end

endmodule

// File: doc/keypad_matrix_emu.md
# keypad_matrix_emu

Emulates the physical 4x4 matrix keypad side of the key-scan interface. It drives the active-low `row` lines in response to the active-low `col` drive from the keypad scanner. This lets the scanner be exercised in simulation and in hardware loopback without a real keypad, with key presses injected from a command port. Each accepted key code produces a timed press, optional contact bounce, release, and an inter-key gap.

## Interface
Parameters:
- TICK_DIV, 1048576: clk cycles per timing tick (≥2).
- HOLD_TICKS, 16: ticks the key is held closed (≥1).
- GAP_TICKS, 16: ticks of released gap after each key (≥1).
- BOUNCE_TICKS, 0: ticks of bounce before press and after release (0 = no bounce).
- BOUNCE_SHIFT, 12: bounce contact toggles every 2^BOUNCE_SHIFT clk cycles.

Ports:
- clk  in  1  system clock.
- enable  in  1  asynchronous active-low reset. Low forces reset immediately.
- col  in  4  column drive from the scanner. A low bit selects that column.
- row  out  4  row sense to the scanner. A low bit means a closed contact in a selected column.
- cmd_valid  in  1  key command present.
- cmd_key  in  5  key code, 1..16, same encoding as the scanner's `key` output.
- cmd_ready  out  1  emulator can accept a command.
- cmd_err  out  1  one-cycle pulse: the accepted code was invalid.
- pressed  out  1  current emulated contact state (1 = closed).
- busy  out  1  a key sequence is in progress.
- done  out  1  one-cycle pulse at the end of a sequence.

## Operation
Key mapping: for code k in 1..16, i = k−1, key row r = i/4 and key column c = i%4.
- Example: k=1 gives (r0, c0). k=2 gives (r0, c1). k=5 gives (r1, c0). k=16 gives (r3, c3).

Row generation (registered every clk):
- row[r] = 0 when pressed=1 and col[c]=0. All other row bits are 1.
- Idle scanner drive col=4'h0 therefore shows the press on row r.

States: IDLE, B_PRESS, HOLD, B_REL, GAP.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&&cmd_ready with a valid code: latch (r,c) and clear the tick counter.
    - Next state is B_PRESS if BOUNCE_TICKS>0, else HOLD.
  - Invalid code (0 or 17..31): the command is consumed, cmd_err pulses, state stays IDLE.
- B_PRESS: pressed = bounce phase bit. Starts at 1 and toggles every 2^BOUNCE_SHIFT cycles. Lasts BOUNCE_TICKS·TICK_DIV cycles, then HOLD.
- HOLD: pressed=1 for HOLD_TICKS·TICK_DIV cycles. Then B_REL if BOUNCE_TICKS>0, else GAP.
- B_REL: pressed = bounce phase, starting at 0. Lasts BOUNCE_TICKS·TICK_DIV cycles, then GAP.
- GAP: pressed=0 for GAP_TICKS·TICK_DIV cycles, then IDLE with done=1 for that first IDLE cycle.

Counters:
- The tick prescaler and the tick counter both clear on every state change, so durations are exact.
- The bounce phase counter clears on entry to B_PRESS and B_REL.
- No counter wraps within a state. Tick counter width is clog2(max(HOLD_TICKS, GAP_TICKS, BOUNCE_TICKS)+1).

Other rules:
- cmd_key is ignored while cmd_ready=0. Commands do not queue.
- col changing at any time only affects row. It never affects the state machine.

## Timing
Reset values (enable low, asynchronous):
- State IDLE, row=4'hF, pressed=0, busy=0, done=0, cmd_err=0, cmd_ready=1.
- Latched key and all counters cleared.

Cycle timing, with accept at clk edge E:
- busy=1 and cmd_ready=0 from E.
- pressed follows the state from E. With BOUNCE_TICKS=0, pressed=1 from E.
- row reflects pressed/col one cycle later (edge E+1).
- With BOUNCE_TICKS=0, pressed is high for exactly HOLD_TICKS·TICK_DIV cycles.
- done and cmd_ready rise at E + (HOLD_TICKS+GAP_TICKS+2·BOUNCE_TICKS)·TICK_DIV.
  - A back-to-back command presented then is accepted that same cycle. done and the new accept coincide.
- cmd_err pulses at edge E with an invalid code. cmd_ready stays 1.

Reset mid-sequence:
- pressed=0 and row=4'hF immediately.
- No done pulse. The in-flight command is lost.

## Test plan
Unless stated otherwise: TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, BOUNCE_TICKS=0.
- Key 6 with col held at 4'h0: row=4'b1101 for exactly 12 cycles starting at E+1, then 4'hF. done pulses at E+20.
- Key 11 while col walks 1110, 1101, 1011, 0111: row=4'b1011 only while col=1011, else 4'hF, with a one-cycle lag.
- cmd_key=0, then cmd_key=17: each produces one cmd_err pulse with no busy and row stays 4'hF. A following key 1 works normally.
- Keys 16 then 1 held valid back-to-back: second accept on the same cycle as the first done. row rows 3 then 0 go low in sequence.
- BOUNCE_TICKS=2, BOUNCE_SHIFT=1, key 1: pressed toggles every 2 cycles for 8 cycles (starting 1), holds 12, toggles 8 (starting 0), then gap 8. done at E+36.
- enable pulsed low during HOLD: row=4'hF and cmd_ready=1 asynchronously, no done. A new key is accepted after release.
